multdiv_sequencer: RTL and testbench

Iterative multiply/divide controller that sits beside the execute stage of the five-stage processor and owns the shared shift-add / shift-subtract datapath. It accepts a one-cycle MULT or DIV request with two 32-bit operands and runs one iteration per clock. While busy it holds the pipeline with `stall`, then presents a signed result and an exception flag for exactly one cycle. A taken branch/jump in the memory stage can abort the operation in flight.

---
 rtl/multdiv_sequencer.sv | 157 +++++++++++++++
 tb/tb_multdiv_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide sequencer (one shift-add/shift-subtract step per clock).
// Build option: define MULTDIV_DIV_EN to include the restoring divider; otherwise DIV traps like divide-by-zero.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_flush,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_count;
    logic            r_op_div;
    logic            r_neg;
    logic [WIDTH-1:0] r_m;
    logic [W2-1:0]   r_acc;
    logic [WIDTH-1:0] r_result;
    logic            r_exc;

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_cneg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [W2-1:0] f_cneg_2w(input logic [W2-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Product fits WIDTH bits only if the top WIDTH+1 bits are a pure sign extension.
    function automatic logic f_mul_ovf(input logic signed [W2-1:0] p);
        return p[W2-1:WIDTH-1] != {(WIDTH+1){p[WIDTH-1]}};
    endfunction

    logic w_start_mult, w_start_div, w_div_run, w_div_trap;
    logic w_last_iter;

    assign w_start_mult = (r_state == S_IDLE) && ctrl_MULT && !ctrl_flush;
    assign w_start_div  = (r_state == S_IDLE) && !ctrl_MULT && ctrl_DIV && !ctrl_flush;
`ifdef MULTDIV_DIV_EN
    assign w_div_run    = w_start_div && (data_operandB != '0);
`else
    assign w_div_run    = 1'b0;
`endif
    assign w_div_trap   = w_start_div && !w_div_run;
    assign w_last_iter  = (r_count == CW'(WIDTH - 1));

    // Multiply step: add multiplicand when the low multiplier bit is set, then shift right.
    logic [WIDTH:0]  w_msum;
    logic [W2-1:0]   w_mul_next;
    logic [W2-1:0]   w_iter;

    assign w_msum     = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
    // Divide step: shift the next dividend bit into the remainder, subtract if it fits.
    logic [WIDTH:0]   w_trial, w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem;
    logic [W2-1:0]    w_div_next;

    assign w_trial    = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_m};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_rem      = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_div_next = {w_rem, r_acc[WIDTH-2:0], w_ge};
    assign w_iter     = r_op_div ? w_div_next : w_mul_next;
`else
    assign w_iter     = w_mul_next;
`endif

    logic signed [W2-1:0]    w_prod_s;
    logic signed [WIDTH-1:0] w_quot_s;
    logic [WIDTH-1:0]        w_fix_result;
    logic                    w_fix_exc;

    assign w_prod_s     = $signed(f_cneg_2w(r_acc, r_neg));
    assign w_quot_s     = $signed(f_cneg_w(r_acc[WIDTH-1:0], r_neg));
    assign w_fix_result = r_op_div ? w_quot_s : w_prod_s[WIDTH-1:0];
    assign w_fix_exc    = r_op_div ? (!r_neg && r_acc[WIDTH-1]) : f_mul_ovf(w_prod_s);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_mult || w_div_run) w_next = S_RUN;
                else if (w_div_trap)           w_next = S_DONE;
            end
            S_RUN: begin
                if (ctrl_flush)       w_next = S_IDLE;
                else if (w_last_iter) w_next = S_FIX;
            end
            S_FIX:   w_next = ctrl_flush ? S_IDLE : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_op_div <= 1'b0;
            r_neg    <= 1'b0;
            r_m      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start_mult) begin
            r_count  <= '0;
            r_op_div <= 1'b0;
            r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_m      <= f_abs(data_operandA);
            r_acc    <= {{WIDTH{1'b0}}, f_abs(data_operandB)};
        end else if (w_div_run) begin
            r_count  <= '0;
            r_op_div <= 1'b1;
            r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_m      <= f_abs(data_operandB);
            r_acc    <= {{WIDTH{1'b0}}, f_abs(data_operandA)};
        end else if (w_div_trap) begin
            r_result <= '0;
            r_exc    <= 1'b1;
        end else if (r_state == S_RUN && !ctrl_flush) begin
            r_acc    <= w_iter;
            r_count  <= r_count + CW'(1);
        end else if (r_state == S_FIX && !ctrl_flush) begin
            r_result <= w_fix_result;
            r_exc    <= w_fix_exc;
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == S_DONE);
    assign stall          = ((r_state == S_IDLE) && (ctrl_MULT || ctrl_DIV))
                            || (r_state == S_RUN) || (r_state == S_FIX);
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: directed corner cases plus randomized MULT/DIV traffic.
module tb_multdiv_sequencer;
    localparam int WIDTH = 32;
`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ctrl_MULT = 1'b0;
    logic             ctrl_DIV = 1'b0;
    logic             ctrl_flush = 1'b0;
    logic [WIDTH-1:0] data_operandA = '0;
    logic [WIDTH-1:0] data_operandB = '0;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             stall;

    multdiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_flush     (ctrl_flush),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .stall          (stall)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    logic [32:0] exp_q[$];
    logic [32:0] prev = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain signed arithmetic. op 0 = MULT, 1 = DIV, 2 = both lines (MULT wins).
    function automatic logic [32:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int q;
        if (op != 1) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p != longint'($signed(p[31:0]))), p[31:0]};
        end
        if (!DIV_EN || b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 1, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("result", data_result, e[31:0]);
                check("exception", data_exception, e[32]);
            end
        end
    end

    task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] e;
        int lat_exp, k;
        bit stall_ok;
        e = model(op, a, b);
        lat_exp = (op == 1 && (!DIV_EN || b == 32'h0)) ? 1 : WIDTH + 2;
        @(negedge clock);
        ctrl_MULT = (op != 1);
        ctrl_DIV  = (op != 0);
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(e);
        #1 check("stall_c0", stall, 1);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        k = 1;
        stall_ok = 1'b1;
        while (!data_resultRDY && k < 200) begin
            if (!stall) stall_ok = 1'b0;
            @(negedge clock);
            k++;
        end
        check("latency", k, lat_exp);
        check("stall_busy", stall_ok, 1);
        check("stall_done", stall, 0);
        prev = e;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int norm;
        #1;
        check("rst_result", data_result, 0);
        check("rst_exc", data_exception, 0);
        check("rst_rdy", data_resultRDY, 0);
        check("rst_stall", stall, 0);
        @(negedge clock);
        reset = 1'b1;

        do_op(0, 32'd6, -32'sd7);
        do_op(0, 32'h4000_0000, 32'd4);
        do_op(1, 32'd100, -32'sd7);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(1, 32'd5, 32'd0);
        do_op(0, 32'h8000_0000, 32'h8000_0000);
        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(1, -32'sd7, 32'd2);
        do_op(1, 32'h8000_0000, 32'd1);

        // Flush in cycle 10 of a MULT: no result, previous result retained.
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (9) @(negedge clock);
        ctrl_flush = 1'b1;
        @(negedge clock);
        ctrl_flush = 1'b0;
        check("flush_stall", stall, 0);
        check("flush_result", data_result, prev[31:0]);
        check("flush_exc", data_exception, prev[32]);
        norm = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) norm++;
        end
        check("flush_no_rdy", norm, 0);
        do_op(0, 32'd2, 32'd2);

        // Reset in cycle 5 of a MULT clears everything at once.
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_result", data_result, 0);
        check("midrst_exc", data_exception, 0);
        check("midrst_rdy", data_resultRDY, 0);
        check("midrst_stall", stall, 0);
        @(negedge clock);
        reset = 1'b1;
        prev = '0;

        do_op(2, 32'd7, 32'd9);
        do_op(2, -32'sd3, 32'd0);

        for (int i = 0; i < 30; i++) begin
            do_op(int'($urandom_range(0, 2)), rnd_operand(), rnd_operand());
        end

        repeat (3) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
